uart_rx_deserializer: RTL and testbench
=======================================

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115_200, the serial bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all flops SHALL be rising-edge.
REQ-004 The block SHALL have port rstn, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-006 The block SHALL have port r_data, output, 8 bits, the last correctly framed byte.
REQ-007 The block SHALL have port r_valid, output, 1 bit, a one-cycle pulse when r_data is updated.
REQ-008 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse when the stop bit is sampled low.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-011 An oversample tick SHALL pulse once every DIV = round(CLK_HZ/(BAUD*16)) clocks; DIV SHALL be at least 1.
REQ-012 The tick counter SHALL free-run from reset, wrap DIV-1 -> 0, and assert tick on the DIV-1 count.
REQ-013 The FSM SHALL have exactly five states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on a tick with rx_s=0, the FSM SHALL go to START and clear the 4-bit tick count.
REQ-015 START: at tick count 7 (mid start bit), if rx_s=0 the FSM SHALL go to DATA with tick count 0 and bit index 0.
REQ-016 START: at tick count 7, if rx_s=1 the FSM SHALL return to IDLE as glitch rejection, with no output pulse.
REQ-017 DATA: every 16th tick, rx_s SHALL shift into an 8-bit register LSB-first (new bit enters MSB, shifts right).
REQ-018 DATA: after bit index 7 is sampled, the FSM SHALL go to STOP.
REQ-019 STOP: at the 16th tick, if rx_s=1, r_data SHALL load the shift register, r_valid SHALL pulse for exactly 1 clock, and the FSM SHALL go to IDLE.
REQ-020 STOP: at the 16th tick, if rx_s=0, frame_err SHALL pulse for 1 clock, r_valid SHALL stay low, r_data SHALL be unchanged, and the FSM SHALL go to WAIT_HIGH.
REQ-021 WAIT_HIGH: the FSM SHALL stay until a tick with rx_s=1, then go to IDLE, so a held-low break yields exactly one frame_err.
REQ-022 r_data SHALL hold its value between r_valid pulses.
REQ-023 r_valid and frame_err SHALL never be high in the same cycle.
REQ-024 Latency: r_valid SHALL rise 2 sync cycles plus about 9.5 bit times after the rx falling edge, within ±1 tick.
REQ-025 Back-to-back frames (one stop bit, zero idle gap) SHALL all be received, since IDLE accepts a start on the tick after STOP.

Reset
REQ-026 While rstn=0, all state SHALL clear asynchronously: FSM=IDLE, counters=0, shift register=0.
REQ-027 While rstn=0: sync flops=1, r_data=8'h30 (ASCII '0'), r_valid=0, frame_err=0, busy=0.
REQ-028 Reset deassertion mid-frame SHALL discard the partial byte; reception SHALL resume at the next start bit.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, OVS=16, and a function computing DIV from CLK_HZ and BAUD.
REQ-030 The tick generator SHALL be sub-module uart_baud_tick (params CLK_HZ, BAUD; ports clk, rstn, tick).
REQ-031 r_data/r_valid SHALL directly drive the downstream digit-register stage with no extra handshake; that stage has no backpressure.

Verification (bench params CLK_HZ=3_200_000, BAUD=100_000: DIV=2, 32 clk/bit)
REQ-032 Single byte 0x35 -> one r_valid pulse, r_data=0x35, frame_err never high.
REQ-033 "12345678" (0x31..0x38) back-to-back, zero gap -> 8 r_valid pulses, data in order, no errors.
REQ-034 rx low for 8 clocks while IDLE -> no r_valid/frame_err, busy returns low within 20 clocks.
REQ-035 0x11, then 0xA5 with stop=0 -> frame_err pulse, r_data stays 0x11; after rx high, 0x3C received correctly.
REQ-036 rx held low for 40 bit times -> exactly one frame_err; then rx high and 0x7E -> r_data=0x7E.
REQ-037 rstn pulsed low during DATA bit 3 -> r_data=0x30 and busy=0 immediately; next frame 0x42 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
`timescale 1ns/1ps
package uart_pkg;

  localparam int OVS = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Rounded clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (baud * OVS) / 2) / (baud * OVS);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clock pulse every DIV clocks.
`timescale 1ns/1ps
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, framing-error detect.
//
// state     | meaning
// IDLE      | line idle, watching for a low sample on a tick
// START     | confirming start bit at its midpoint (tick 7)
// DATA      | sampling 8 data bits, LSB first, every 16th tick
// STOP      | sampling stop bit; high -> byte out, low -> frame_err
// WAIT_HIGH | after a framing error, wait for the line to go high
`timescale 1ns/1ps
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] r_data,
  output logic       r_valid,
  output logic       frame_err,
  output logic       busy
);

  logic [1:0] r_sync;
  logic       w_rx_s;
  logic       w_tick;
  rx_state_t  r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s = r_sync[1];
  assign busy   = (r_state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= 8'h30;
      r_valid    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      frame_err <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state    <= START;
              r_tick_cnt <= '0;
            end
          end
          START: begin
            if (r_tick_cnt == 4'd7) begin
              r_tick_cnt <= '0;
              r_bit_idx  <= '0;
              r_state    <= w_rx_s ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          DATA: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_shift <= {w_rx_s, r_shift[7:1]};
              if (r_bit_idx == 3'd7) begin
                r_state <= STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end
          end
          STOP: begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              if (w_rx_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            if (w_rx_s) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer at 32 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int CLK_HZ   = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLKS = 32;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [7:0] r_data;
  logic       r_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_deserializer #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .r_data    (r_data),
    .r_valid   (r_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor records DUT output events; the test tasks do the comparing.
  logic [7:0] got_data [0:255];
  int         got_cyc  [0:255];
  int         got_n   = 0;
  int         fe_cnt  = 0;
  int         overlap = 0;

  always @(negedge clk) begin
    if (r_valid) begin
      got_data[got_n[7:0]] = r_data;
      got_cyc[got_n[7:0]]  = cyc;
      got_n = got_n + 1;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (r_valid && frame_err) overlap = overlap + 1;
  end

  logic [7:0] exp_q [$];
  int rd_ptr = 0;
  int start_cyc = 0;

  task automatic drive_bits(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    drive_bits(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_CLKS);
    drive_bits(stop, BIT_CLKS);
  endtask

  task automatic wait_frames(input int n, input string name);
    int t;
    t = 0;
    while (got_n < rd_ptr + n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (got_n < rd_ptr + n) begin
      errors++;
      $display("FAIL %s timeout: got %0d frames, required %0d", name, got_n - rd_ptr, n);
    end
  endtask

  task automatic pop_compare(input string name);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (rd_ptr >= got_n) begin
        errors++;
        $display("FAIL %s: no frame received, required %02h", name, e);
      end else begin
        if (got_data[rd_ptr[7:0]] !== e) begin
          errors++;
          $display("FAIL %s: got %02h, required %02h", name, got_data[rd_ptr[7:0]], e);
        end
        rd_ptr++;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (r_data !== 8'h30) begin errors++; $display("FAIL reset_data: got %02h, required 30", r_data); end
    checks++;
    if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", r_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int fe0, lat;
    fe0 = fe_cnt;
    exp_q.push_back(8'h35);
    send_byte(8'h35, 1'b1);
    drive_bits(1'b1, BIT_CLKS);
    wait_frames(1, "single");
    lat = (rd_ptr < got_n) ? got_cyc[rd_ptr[7:0]] - start_cyc : -1;
    pop_compare("single_data");
    checks++;
    if (lat < 304 || lat > 309) begin
      errors++;
      $display("FAIL single_latency: got %0d clocks, required 304..309", lat);
    end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL single_ferr: got %0d, required 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    int fe0;
    fe0 = fe_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 8; i++) send_byte(8'h31 + 8'(i), 1'b1);
    drive_bits(1'b1, 2 * BIT_CLKS);
    wait_frames(8, "b2b");
    for (int i = 0; i < 8; i++) pop_compare("b2b_data");
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL b2b_ferr: got %0d, required 0", fe_cnt - fe0); end
  endtask

  task automatic test_glitch();
    int fe0, n0, t;
    fe0 = fe_cnt;
    n0  = got_n;
    drive_bits(1'b0, 8);
    rx = 1'b1;
    t = 0;
    while (busy !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b, required 0", busy); end
    drive_bits(1'b1, 2 * BIT_CLKS);
    checks++;
    if (got_n != n0) begin errors++; $display("FAIL glitch_valid: got %0d pulses, required 0", got_n - n0); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_ferr: got %0d, required 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    wait_frames(1, "ferr_first");
    pop_compare("ferr_first_data");
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0);
    drive_bits(1'b1, 2 * BIT_CLKS);
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_count: got %0d, required 1", fe_cnt - fe0); end
    checks++;
    if (got_n != rd_ptr) begin errors++; $display("FAIL ferr_valid: got %0d pulses, required 0", got_n - rd_ptr); end
    checks++;
    if (r_data !== 8'h11) begin errors++; $display("FAIL ferr_hold: got %02h, required 11", r_data); end
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    drive_bits(1'b1, BIT_CLKS);
    wait_frames(1, "ferr_recover");
    pop_compare("ferr_recover_data");
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    drive_bits(1'b0, 40 * BIT_CLKS);
    drive_bits(1'b1, 2 * BIT_CLKS);
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL break_count: got %0d, required 1", fe_cnt - fe0); end
    checks++;
    if (got_n != rd_ptr) begin errors++; $display("FAIL break_valid: got %0d pulses, required 0", got_n - rd_ptr); end
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    drive_bits(1'b1, BIT_CLKS);
    wait_frames(1, "break_recover");
    pop_compare("break_recover_data");
    checks++;
    if (r_data !== 8'h7E) begin errors++; $display("FAIL break_rdata: got %02h, required 7e", r_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h5A;
    drive_bits(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive_bits(d[i], BIT_CLKS);
    drive_bits(d[3], BIT_CLKS / 2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, required 1", busy); end
    rstn = 1'b0;
    rx   = 1'b1;
    #1;
    checks++;
    if (r_data !== 8'h30) begin errors++; $display("FAIL midrst_data: got %02h, required 30", r_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    @(negedge clk);
    rstn = 1'b1;
    drive_bits(1'b1, 2 * BIT_CLKS);
    checks++;
    if (got_n != rd_ptr) begin errors++; $display("FAIL midrst_valid: got %0d pulses, required 0", got_n - rd_ptr); end
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    drive_bits(1'b1, BIT_CLKS);
    wait_frames(1, "midrst_recover");
    pop_compare("midrst_recover_data");
  endtask

  initial begin
    rstn = 1'b0;
    rx   = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL valid_ferr_overlap: got %0d cycles, required 0", overlap); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size()); end
    checks++;
    if (got_n != rd_ptr) begin errors++; $display("FAIL extra_frames: got %0d unmatched, required 0", got_n - rd_ptr); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
